instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 137 +++++++++++++
 tb/tb_instr_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: LOAD fills instruction memory word by word,
// COMMIT publishes the loaded length to fetch, CLEAR fills the memory with NOPs.
module instr_loader #(
  parameter int          n_blocks        = 256,
  parameter logic [4:0]  BLOCK_INSTR_NOP = 5'd0,
  localparam int         AW              = $clog2(n_blocks)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] instr_write_addr,
  output logic [31:0]   instr_write_val,
  output logic          instr_write_enable,
  output logic [AW-1:0] n_blocks_running,
  output logic [AW-1:0] last_block,
  output logic          busy,
  output logic          error
);

  typedef enum logic [1:0] {IDLE, COUNT, DATA, CLEAR} state_t;

  localparam logic [7:0]    CMD_LOAD   = 8'h01;
  localparam logic [7:0]    CMD_COMMIT = 8'h02;
  localparam logic [7:0]    CMD_CLEAR  = 8'h03;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(n_blocks - 1);

  state_t        state_q;
  logic [AW-1:0] w_q;
  logic [1:0]    b_q;
  // Lengths carry one extra bit so a full-depth load (L == n_blocks) is representable.
  logic [AW:0]   len_q;
  logic [AW:0]   loaded_q;
  logic [31:0]   word_q;

  logic          accept;
  logic [8:0]    len_d;
  logic          last_word;

  assign in_ready  = (state_q != CLEAR);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign len_d     = {1'b0, in_data} + 9'd1;
  assign last_word = ({1'b0, w_q} == (len_q - (AW+1)'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      w_q                <= '0;
      b_q                <= '0;
      len_q              <= '0;
      loaded_q           <= '0;
      word_q             <= '0;
      n_blocks_running   <= '0;
      last_block         <= '0;
      instr_write_enable <= 1'b0;
      instr_write_addr   <= '0;
      instr_write_val    <= '0;
      error              <= 1'b0;
    end else begin
      instr_write_enable <= 1'b0;
      error              <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (in_data)
              CMD_LOAD: begin
                n_blocks_running <= '0;
                state_q          <= COUNT;
              end
              CMD_COMMIT: begin
                if (loaded_q != '0) begin
                  n_blocks_running <= AW'(loaded_q);
                  last_block       <= AW'(loaded_q - (AW+1)'(1));
                end else begin
                  n_blocks_running <= '0;
                  last_block       <= '0;
                end
              end
              CMD_CLEAR: begin
                n_blocks_running <= '0;
                loaded_q         <= '0;
                w_q              <= '0;
                state_q          <= CLEAR;
              end
              default: error <= 1'b1;
            endcase
          end
        end
        COUNT: begin
          if (accept) begin
            if (int'(len_d) > n_blocks) begin
              error   <= 1'b1;
              state_q <= IDLE;
            end else begin
              len_q   <= (AW+1)'(len_d);
              w_q     <= '0;
              b_q     <= '0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            b_q <= b_q + 2'd1;
            if (b_q == 2'd3) begin
              instr_write_enable <= 1'b1;
              instr_write_addr   <= w_q;
              instr_write_val    <= {in_data, word_q[23:0]};
              if (last_word) begin
                loaded_q <= len_q;
                state_q  <= IDLE;
              end else begin
                w_q <= w_q + AW'(1);
              end
            end else begin
              word_q[8*b_q +: 8] <= in_data;
            end
          end
        end
        CLEAR: begin
          instr_write_enable <= 1'b1;
          instr_write_addr   <= w_q;
          instr_write_val    <= {27'd0, BLOCK_INSTR_NOP};
          w_q                <= w_q + AW'(1);
          if (w_q == LAST_ADDR) begin
            last_block <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued as bytes are
// driven and popped as the write strobe appears.
module tb_instr_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] instr_write_addr;
  logic [31:0]   instr_write_val;
  logic          instr_write_enable;
  logic [AW-1:0] n_blocks_running;
  logic [AW-1:0] last_block;
  logic          busy;
  logic          error;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];

  instr_loader #(.n_blocks(256)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .instr_write_addr   (instr_write_addr),
    .instr_write_val    (instr_write_val),
    .instr_write_enable (instr_write_enable),
    .n_blocks_running   (n_blocks_running),
    .last_block         (last_block),
    .busy               (busy),
    .error              (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (instr_write_enable) begin
      if (exp_q.size() > 0) begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(instr_write_addr), 64'(e[39:32]));
        chk("wr_val",  64'(instr_write_val),  64'(e[31:0]));
      end else begin
        chk("unexpected_write", 64'(instr_write_enable), 64'd0);
      end
    end
  end

  // Returns one time unit after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] a, input logic [31:0] v);
    exp_q.push_back({a, v});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_nbr"},  64'(n_blocks_running),   64'd0);
    chk({tag, "_last"}, 64'(last_block),         64'd0);
    chk({tag, "_busy"}, 64'(busy),               64'd0);
    chk({tag, "_err"},  64'(error),              64'd0);
    chk({tag, "_we"},   64'(instr_write_enable), 64'd0);
    chk({tag, "_addr"}, 64'(instr_write_addr),   64'd0);
    chk({tag, "_val"},  64'(instr_write_val),    64'd0);
    chk({tag, "_rdy"},  64'(in_ready),           64'd1);
  endtask

  initial begin
    logic [7:0]  bytes[12];
    logic [31:0] w;
    int          cnt;

    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    idle_cycles(3);
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;

    // Two-word load with a stall mid-word, then commit.
    send(8'h01);
    chk("load_busy", 64'(busy), 64'd1);
    send(8'h01);
    push_word(8'd0, 32'h12345678);
    push_word(8'd1, 32'hDEADBEEF);
    send(8'h78); send(8'h56);
    idle_cycles(5);
    send(8'h34); send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("load_done_busy", 64'(busy), 64'd0);
    idle_cycles(2);
    chk("precommit_nbr", 64'(n_blocks_running), 64'd0);
    chk("precommit_last", 64'(last_block), 64'd0);
    send(8'h02);
    chk("commit_nbr", 64'(n_blocks_running), 64'd2);
    chk("commit_last", 64'(last_block), 64'd1);

    // New LOAD halts fetch immediately; three random words.
    send(8'h01);
    chk("reload_nbr", 64'(n_blocks_running), 64'd0);
    send(8'h02);
    for (int i = 0; i < 12; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) begin
      w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      push_word(8'(i), w);
    end
    for (int i = 0; i < 12; i++) send(bytes[i]);
    idle_cycles(1);
    chk("rand_precommit_nbr", 64'(n_blocks_running), 64'd0);
    send(8'h02);
    chk("rand_commit_nbr", 64'(n_blocks_running), 64'd3);
    chk("rand_commit_last", 64'(last_block), 64'd2);

    // CLEAR: 256 NOP writes, busy for exactly 256 cycles.
    for (int i = 0; i < 256; i++) push_word(8'(i), 32'd0);
    send(8'h03);
    chk("clr_ready", 64'(in_ready), 64'd0);
    chk("clr_nbr", 64'(n_blocks_running), 64'd0);
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("clr_busy_cycles", 64'(cnt), 64'd256);
    chk("clr_last", 64'(last_block), 64'd0);
    chk("clr_done_ready", 64'(in_ready), 64'd1);
    idle_cycles(2);
    chk("clr_queue_empty", 64'(exp_q.size()), 64'd0);

    // Unknown command pulses error for one cycle; empty commit yields zeros.
    chk("err_idle", 64'(error), 64'd0);
    send(8'h7F);
    chk("err_pulse", 64'(error), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    idle_cycles(1);
    chk("err_gone", 64'(error), 64'd0);
    send(8'h02);
    chk("empty_commit_nbr", 64'(n_blocks_running), 64'd0);
    chk("empty_commit_last", 64'(last_block), 64'd0);

    // Stalled LOAD abandoned by reset, then a fresh single-word load.
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    idle_cycles(10);
    chk("stall_busy", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(2);
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    push_word(8'd0, 32'hC0FFEE01);
    send(8'h01); send(8'h00);
    send(8'h01); send(8'hEE); send(8'hFF); send(8'hC0);
    send(8'h02);
    chk("final_nbr", 64'(n_blocks_running), 64'd1);
    chk("final_last", 64'(last_block), 64'd0);
    idle_cycles(3);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
